// File: rtl/mem_arbiter.sv
// Two-port memory arbiter between instruction fetch and load/store. It makes at most one grant
// per cycle, returns the response one cycle later, and caps data bursts while a fetch waits.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int WORD_WIDTH  = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifReq,
  input  logic [ADDR_WIDTH-1:0] ifAddr,
  output logic                  ifGnt,
  output logic                  ifValid,
  output logic                  ifErr,
  output logic [WORD_WIDTH-1:0] ifData,
  input  logic                  dReq,
  input  logic                  dWe,
  input  logic [1:0]            dUnit,
  input  logic [ADDR_WIDTH-1:0] dAddr,
  input  logic [WORD_WIDTH-1:0] dWdata,
  output logic                  dGnt,
  output logic                  dValid,
  output logic                  dErr,
  output logic [WORD_WIDTH-1:0] dRdata,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [1:0]            addrUnit,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] dataIn,
  input  logic [WORD_WIDTH-1:0] dataOut
);

  localparam logic [1:0] UNIT_BYTE = 2'd0;
  localparam logic [1:0] UNIT_HALF = 2'd1;
  localparam logic [1:0] UNIT_WORD = 2'd2;
  localparam logic [1:0] UNIT_NOP  = 2'd3;
  localparam int CNT_W = $clog2(MAX_D_BURST + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  function automatic logic is_aligned(input logic [1:0] unit, input logic [1:0] lsb);
    case (unit)
      UNIT_HALF: return ~lsb[0];
      UNIT_WORD: return (lsb == 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

  owner_t           resp_owner_p1, owner_nxt;
  logic             err_p1, err_nxt;
  logic             zero_p1, zero_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic             burst_full, if_ok, d_ok, d_nop;

  assign burst_full = (burst_cnt == CNT_W'(MAX_D_BURST));
  assign if_ok      = (ifAddr[1:0] == 2'b00);
  assign d_nop      = (dUnit == UNIT_NOP);
  assign d_ok       = is_aligned(dUnit, dAddr[1:0]);

  // Data normally wins; a full burst count hands the slot to a waiting fetch.
  assign ifGnt = rst_n & ifReq & (~dReq | burst_full);
  assign dGnt  = rst_n & dReq & ~(ifReq & burst_full);

  always_comb begin
    memRead  = 1'b0;
    memWrite = 1'b0;
    addrUnit = UNIT_BYTE;
    address  = '0;
    dataIn   = '0;
    if (ifGnt) begin
      address  = ifAddr;
      addrUnit = UNIT_WORD;
      memRead  = if_ok;
    end else if (dGnt) begin
      address  = dAddr;
      addrUnit = dUnit;
      dataIn   = dWdata;
      memRead  = ~dWe & d_ok & ~d_nop;
      memWrite = dWe & d_ok & ~d_nop;
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    err_nxt   = 1'b0;
    zero_nxt  = 1'b0;
    if (ifGnt) begin
      owner_nxt = OWN_IF;
      err_nxt   = ~if_ok;
    end else if (dGnt) begin
      owner_nxt = OWN_D;
      err_nxt   = ~d_nop & ~d_ok;
      zero_nxt  = d_nop | dWe;
    end
    if (~ifReq || ifGnt)
      burst_nxt = '0;
    else if (dGnt && !burst_full)
      burst_nxt = burst_cnt + CNT_W'(1);
    else
      burst_nxt = burst_cnt;
  end

  // ---- stage p1: response register, delivered the cycle after the grant ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner_p1 <= OWN_NONE;
      err_p1        <= 1'b0;
      zero_p1       <= 1'b0;
      burst_cnt     <= '0;
    end else begin
      resp_owner_p1 <= owner_nxt;
      err_p1        <= err_nxt;
      zero_p1       <= zero_nxt;
      burst_cnt     <= burst_nxt;
    end
  end

  always_comb begin
    ifValid = (resp_owner_p1 == OWN_IF);
    dValid  = (resp_owner_p1 == OWN_D);
    ifErr   = ifValid & err_p1;
    dErr    = dValid & err_p1;
    ifData  = (ifValid && !err_p1) ? dataOut : '0;
    dRdata  = (dValid && !err_p1 && !zero_p1) ? dataOut : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference of the grant and response rules.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int WW   = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifReq, ifGnt, ifValid, ifErr;
  logic [AW-1:0] ifAddr;
  logic [WW-1:0] ifData;
  logic          dReq, dWe, dGnt, dValid, dErr;
  logic [1:0]    dUnit;
  logic [AW-1:0] dAddr;
  logic [WW-1:0] dWdata, dRdata;
  logic          memRead, memWrite;
  logic [1:0]    addrUnit;
  logic [AW-1:0] address;
  logic [WW-1:0] dataIn;
  logic [WW-1:0] dataOut = '0;

  int n_pass = 0;
  int n_checks = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifValid(ifValid), .ifErr(ifErr), .ifData(ifData),
    .dReq(dReq), .dWe(dWe), .dUnit(dUnit), .dAddr(dAddr), .dWdata(dWdata),
    .dGnt(dGnt), .dValid(dValid), .dErr(dErr), .dRdata(dRdata),
    .memRead(memRead), .memWrite(memWrite), .addrUnit(addrUnit), .address(address),
    .dataIn(dataIn), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16: return 8'hEF;
      17: return 8'hBE;
      18: return 8'hAD;
      19: return 8'hDE;
      default: return 8'(i * 29 + 7);
    endcase
  endfunction

  // Synchronous byte memory: zero-extending loads, data available the cycle after memRead.
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      mem_ready <= 1'b1;
    end else begin
      if (memWrite) begin
        mem[address[7:0]] <= dataIn[7:0];
        if (addrUnit != 2'd0) mem[address[7:0] + 8'd1] <= dataIn[15:8];
        if (addrUnit == 2'd2) begin
          mem[address[7:0] + 8'd2] <= dataIn[23:16];
          mem[address[7:0] + 8'd3] <= dataIn[31:24];
        end
      end
      if (memRead) begin
        case (addrUnit)
          2'd0:    dataOut <= {24'd0, mem[address[7:0]]};
          2'd1:    dataOut <= {16'd0, mem[address[7:0] + 8'd1], mem[address[7:0]]};
          default: dataOut <= {mem[address[7:0] + 8'd3], mem[address[7:0] + 8'd2],
                               mem[address[7:0] + 8'd1], mem[address[7:0]]};
        endcase
      end
    end
  end

  // Reference contents as the requesters see them.
  logic [7:0] ref_mem [256];

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] u);
    case (u)
      2'd0:    return {24'd0, ref_mem[a]};
      2'd1:    return {16'd0, ref_mem[a + 8'd1], ref_mem[a]};
      default: return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endcase
  endfunction

  task automatic ref_store(input logic [7:0] a, input logic [1:0] u, input logic [31:0] d);
    ref_mem[a] = d[7:0];
    if (u != 2'd0) ref_mem[a + 8'd1] = d[15:8];
    if (u == 2'd2) begin
      ref_mem[a + 8'd2] = d[23:16];
      ref_mem[a + 8'd3] = d[31:24];
    end
  endtask

  task automatic test_reset;
    ifReq = 1'b1; ifAddr = 32'h0; dReq = 1'b1; dWe = 1'b0; dUnit = 2'd2; dAddr = 32'h40; dWdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ifGnt !== 1'b0) $display("FAIL reset_ifGnt: got %b want 0", ifGnt); else n_pass++;
    n_checks++; if (dGnt !== 1'b0) $display("FAIL reset_dGnt: got %b want 0", dGnt); else n_pass++;
    n_checks++; if ({memRead, memWrite} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {memRead, memWrite}); else n_pass++;
    n_checks++; if ({ifValid, dValid, ifErr, dErr} !== 4'b0) $display("FAIL reset_resp: got %b want 0000", {ifValid, dValid, ifErr, dErr}); else n_pass++;
    ifReq = 1'b0; dReq = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_fetch;
    @(posedge clk); #1 ifReq = 1'b1; ifAddr = 32'h10;
    @(negedge clk);
    n_checks++; if ({ifGnt, dGnt} !== 2'b10) $display("FAIL fetch_gnt: got %b want 10", {ifGnt, dGnt}); else n_pass++;
    n_checks++; if ({memRead, memWrite} !== 2'b10) $display("FAIL fetch_strobe: got %b want 10", {memRead, memWrite}); else n_pass++;
    n_checks++; if (addrUnit !== 2'd2 || address !== 32'h10) $display("FAIL fetch_addr: got %0d/%h want 2/00000010", addrUnit, address); else n_pass++;
    @(posedge clk); #1 ifReq = 1'b0;
    @(negedge clk);
    n_checks++; if ({ifValid, ifErr} !== 2'b10) $display("FAIL fetch_valid: got %b want 10", {ifValid, ifErr}); else n_pass++;
    n_checks++; if (ifData !== 32'hDEADBEEF) $display("FAIL fetch_data: got %h want deadbeef", ifData); else n_pass++;
  endtask

  task automatic test_store_load;
    @(posedge clk); #1 dReq = 1'b1; dWe = 1'b1; dUnit = 2'd0; dAddr = 32'h21; dWdata = 32'h123456AB;
    @(negedge clk);
    n_checks++; if ({dGnt, memWrite, memRead} !== 3'b110) $display("FAIL store_gnt: got %b want 110", {dGnt, memWrite, memRead}); else n_pass++;
    n_checks++; if (dataIn[7:0] !== 8'hAB) $display("FAIL store_dataIn: got %h want ab", dataIn[7:0]); else n_pass++;
    ref_store(8'h21, 2'd0, 32'h123456AB);
    @(posedge clk); #1 dWe = 1'b0;
    @(negedge clk);
    n_checks++; if ({dValid, dErr, dRdata} !== {2'b10, 32'h0}) $display("FAIL store_ack: got %b%b/%h want 10/0", dValid, dErr, dRdata); else n_pass++;
    n_checks++; if ({dGnt, memRead, memWrite} !== 3'b110) $display("FAIL load_gnt: got %b want 110", {dGnt, memRead, memWrite}); else n_pass++;
    @(posedge clk); #1 dReq = 1'b0;
    @(negedge clk);
    n_checks++; if ({dValid, dErr} !== 2'b10 || dRdata !== 32'h000000AB) $display("FAIL load_data: got %b%b/%h want 10/000000ab", dValid, dErr, dRdata); else n_pass++;
  endtask

  task automatic test_burst;
    logic prev_if = 1'b0;
    @(posedge clk); #1 ifReq = 1'b1; ifAddr = 32'h0; dReq = 1'b1; dWe = 1'b0; dUnit = 2'd2; dAddr = 32'h40;
    for (int k = 0; k < 20; k++) begin
      logic exp_if;
      @(negedge clk);
      exp_if = (k % 5 == 4);
      n_checks++; if ({ifGnt, dGnt} !== {exp_if, ~exp_if}) $display("FAIL burst_gnt[%0d]: got %b want %b", k, {ifGnt, dGnt}, {exp_if, ~exp_if}); else n_pass++;
      if (k > 0) begin
        n_checks++; if ({ifValid, dValid} !== {prev_if, ~prev_if}) $display("FAIL burst_valid[%0d]: got %b want %b", k, {ifValid, dValid}, {prev_if, ~prev_if}); else n_pass++;
      end
      prev_if = exp_if;
      @(posedge clk);
    end
    #1 ifReq = 1'b0; dReq = 1'b0;
    @(negedge clk);
    n_checks++; if (ifValid !== 1'b1) $display("FAIL burst_last_if: got %b want 1", ifValid); else n_pass++;
  endtask

  task automatic test_misaligned;
    @(posedge clk); #1 dReq = 1'b1; dWe = 1'b0; dUnit = 2'd2; dAddr = 32'h22;
    @(negedge clk);
    n_checks++; if ({dGnt, memRead, memWrite} !== 3'b100) $display("FAIL mis_load_gnt: got %b want 100", {dGnt, memRead, memWrite}); else n_pass++;
    @(posedge clk); #1 dReq = 1'b0; ifReq = 1'b1; ifAddr = 32'h06;
    @(negedge clk);
    n_checks++; if ({dValid, dErr, dRdata} !== {2'b11, 32'h0}) $display("FAIL mis_load_resp: got %b%b/%h want 11/0", dValid, dErr, dRdata); else n_pass++;
    n_checks++; if ({ifGnt, memRead} !== 2'b10) $display("FAIL mis_fetch_gnt: got %b want 10", {ifGnt, memRead}); else n_pass++;
    @(posedge clk); #1 ifReq = 1'b0;
    @(negedge clk);
    n_checks++; if ({ifValid, ifErr, ifData} !== {2'b11, 32'h0}) $display("FAIL mis_fetch_resp: got %b%b/%h want 11/0", ifValid, ifErr, ifData); else n_pass++;
  endtask

  task automatic test_nop;
    @(posedge clk); #1 dReq = 1'b1; dWe = 1'b0; dUnit = 2'd3; dAddr = 32'h31;
    @(negedge clk);
    n_checks++; if ({dGnt, memRead, memWrite} !== 3'b100) $display("FAIL nop_gnt: got %b want 100", {dGnt, memRead, memWrite}); else n_pass++;
    @(posedge clk); #1 dReq = 1'b0;
    @(negedge clk);
    n_checks++; if ({dValid, dErr, dRdata} !== {2'b10, 32'h0}) $display("FAIL nop_resp: got %b%b/%h want 10/0", dValid, dErr, dRdata); else n_pass++;
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1 ifReq = 1'b1; ifAddr = 32'h0; dReq = 1'b1; dWe = 1'b0; dUnit = 2'd2; dAddr = 32'h10;
    @(negedge clk);
    n_checks++; if (dGnt !== 1'b1) $display("FAIL ar_pre_gnt: got %b want 1", dGnt); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (dValid !== 1'b1) $display("FAIL ar_pre_valid: got %b want 1", dValid); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (dValid !== 1'b0) $display("FAIL ar_valid_drop: got %b want 0", dValid); else n_pass++;
    n_checks++; if ({ifGnt, dGnt, memRead, memWrite} !== 4'b0) $display("FAIL ar_gnt_forced: got %b want 0000", {ifGnt, dGnt, memRead, memWrite}); else n_pass++;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic exp_if;
      @(negedge clk);
      exp_if = (k == 4);
      if (k == 0) begin
        n_checks++; if ({ifValid, dValid} !== 2'b00) $display("FAIL ar_post_valid: got %b want 00", {ifValid, dValid}); else n_pass++;
      end
      n_checks++; if ({ifGnt, dGnt} !== {exp_if, ~exp_if}) $display("FAIL ar_burst[%0d]: got %b want %b", k, {ifGnt, dGnt}, {exp_if, ~exp_if}); else n_pass++;
      @(posedge clk);
    end
    #1 ifReq = 1'b0; dReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    int m_burst = 0;
    int exp_owner = 0;
    logic exp_err = 1'b0;
    logic [31:0] exp_data = '0;
    @(posedge clk); #1;
    ifReq = ($urandom % 4) != 0; ifAddr = 32'({6'($urandom), 2'b00});
    dReq = ($urandom % 4) != 0; dWe = 1'($urandom); dUnit = 2'($urandom); dAddr = 32'(8'($urandom)); dWdata = $urandom;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic e_ig, e_dg, nop, mis;
      @(negedge clk);
      e_ig = ifReq && (!dReq || m_burst == MAXB);
      e_dg = dReq && !e_ig;
      n_checks++; if ({ifGnt, dGnt} !== {e_ig, e_dg}) $display("FAIL rnd_gnt[%0d]: got %b want %b", cyc, {ifGnt, dGnt}, {e_ig, e_dg}); else n_pass++;
      n_checks++; if (memRead === 1'b1 && memWrite === 1'b1) $display("FAIL rnd_strobes[%0d]: got 11 want not both", cyc); else n_pass++;
      n_checks++; if ({ifValid, dValid} !== {exp_owner == 1, exp_owner == 2}) $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, {ifValid, dValid}, {exp_owner == 1, exp_owner == 2}); else n_pass++;
      if (exp_owner == 1) begin
        n_checks++; if ({ifErr, ifData} !== {exp_err, exp_data}) $display("FAIL rnd_if_resp[%0d]: got %b/%h want %b/%h", cyc, ifErr, ifData, exp_err, exp_data); else n_pass++;
      end else if (exp_owner == 2) begin
        n_checks++; if ({dErr, dRdata} !== {exp_err, exp_data}) $display("FAIL rnd_d_resp[%0d]: got %b/%h want %b/%h", cyc, dErr, dRdata, exp_err, exp_data); else n_pass++;
      end
      exp_owner = 0; exp_err = 1'b0; exp_data = '0;
      if (e_ig) begin
        exp_owner = 1;
        exp_err = (ifAddr[1:0] != 2'b00);
        if (!exp_err) exp_data = ref_load(ifAddr[7:0], 2'd2);
      end else if (e_dg) begin
        exp_owner = 2;
        nop = (dUnit == 2'd3);
        mis = !nop && ((dUnit == 2'd1 && dAddr[0]) || (dUnit == 2'd2 && dAddr[1:0] != 2'b00));
        exp_err = mis;
        if (!nop && !mis) begin
          if (dWe) ref_store(dAddr[7:0], dUnit, dWdata);
          else exp_data = ref_load(dAddr[7:0], dUnit);
        end
      end
      if (e_ig || !ifReq) m_burst = 0;
      else if (e_dg && m_burst < MAXB) m_burst++;
      @(posedge clk); #1;
      if (e_ig || !ifReq) begin
        ifReq = ($urandom % 4) != 0;
        ifAddr = 32'({6'($urandom), 2'b00});
        if ($urandom % 8 == 0) ifAddr = ifAddr + 32'($urandom % 4);
      end
      if (e_dg || !dReq) begin
        dReq = ($urandom % 4) != 0; dWe = 1'($urandom); dUnit = 2'($urandom);
        dAddr = 32'(8'($urandom)); dWdata = $urandom;
      end
    end
    ifReq = 1'b0; dReq = 1'b0;
  endtask

  initial begin
    ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWe = 1'b0; dUnit = 2'd0; dAddr = '0; dWdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    test_reset;
    test_fetch;
    test_store_load;
    test_burst;
    test_misaligned;
    test_nop;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
